// File: rtl/fx2_stream_writer.sv
// fx2_stream_writer
//   ADC-to-FX2LP synchronous slave-FIFO streamer on the 48 MHz IFCLK domain.
//   Samples are decimated by DIV, buffered in a small FIFO so that FX2 full
//   stalls do not lose data, and written out over the slave-FIFO bus.
//   Samples that arrive while the buffer is full are counted in DROP_CNT.
//   When ENABLE falls, the buffer is drained and any short packet is
//   committed with a single PKTENDN pulse.
//
// Ports
//   CLK       IFCLK; all logic runs on its rising edge
//   RESET     asynchronous, active-high; clears all state
//   ENABLE    level: 1 = stream, 0 = stop, drain and commit
//   DIV       decimation divisor (0 and 1 both mean every cycle)
//   PKT_LEN   FX2 endpoint packet size in words (0 = never PKTEND)
//   SAMPLE    registered ADC data, valid every cycle
//   FULLN     FX2 full flag, 1 = room (configure as almost-full by >= 1 word)
//   FD        FX2 data bus
//   SLWRN     FX2 write strobe, active-low
//   PKTENDN   FX2 packet end, active-low
//   BUSY      high in any state other than IDLE
//   LEVEL     FIFO occupancy
//   DROP_CNT  samples lost to FIFO full, saturating, cleared on IDLE->STREAM
//
// Write handshake: FULLN acts as "ready" and the registered SLWRN as "valid".
// A word is transferred in every cycle where SLWRN=0; the pop decision is
// taken one cycle earlier, only while FULLN=1, so SLWRN never asserts
// because of a FULLN sample taken in the same cycle.
module fx2_stream_writer #(
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 4,
  parameter int DIV_W   = 26,
  parameter int PKT_W   = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               ENABLE,
  input  logic [DIV_W-1:0]   DIV,
  input  logic [PKT_W-1:0]   PKT_LEN,
  input  logic [DATA_W-1:0]  SAMPLE,
  input  logic               FULLN,
  output logic [DATA_W-1:0]  FD,
  output logic               SLWRN,
  output logic               PKTENDN,
  output logic               BUSY,
  output logic [FIFO_AW:0]   LEVEL,
  output logic [15:0]        DROP_CNT
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_PKTEND = 2'd3
  } state_t;

  state_t state;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   level;
  logic [DIV_W-1:0]   dec_cnt;
  logic [DIV_W-1:0]   div_cur;
  logic [DIV_W-1:0]   div_last;
  logic [PKT_W-1:0]   pkt_cnt;

  logic start;
  logic strobe;
  logic fifo_full;
  logic pop;
  logic push;
  logic drop;
  logic dec_wrap;
  logic drain_done;

  // Divisor in use is latched at each wrap, so a DIV change only shifts the
  // strobe spacing from the next period on.
  assign div_last   = (div_cur == '0) ? '0 : div_cur - DIV_W'(1);
  assign dec_wrap   = (dec_cnt >= div_last);
  assign start      = (state == S_IDLE) && ENABLE;
  assign strobe     = (state == S_STREAM) && (dec_cnt == '0);
  assign fifo_full  = (level == DEPTH_L);
  assign pop        = ((state == S_STREAM) || (state == S_DRAIN)) &&
                      (level != '0) && FULLN;
  // A full FIFO still accepts a sample when a word leaves in the same cycle.
  assign push       = strobe && (!fifo_full || pop);
  assign drop       = strobe && fifo_full && !pop;
  // SLWRN=0 means a word is on the bus this cycle and the packet counter has
  // not yet absorbed it, so draining waits for the strobe to return high.
  assign drain_done = (level == '0) && SLWRN;

  assign BUSY  = (state != S_IDLE);
  assign LEVEL = level;

  // FIFO storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= SAMPLE;
  end

  // Datapath: decimator, FIFO pointers, bus outputs and counters.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      dec_cnt  <= '0;
      div_cur  <= '0;
      FD       <= '0;
      SLWRN    <= 1'b1;
      DROP_CNT <= '0;
      pkt_cnt  <= '0;
    end else begin
      if (state == S_STREAM) begin
        if (dec_wrap) begin
          dec_cnt <= '0;
          div_cur <= DIV;
        end else begin
          dec_cnt <= dec_cnt + DIV_W'(1);
        end
      end else begin
        dec_cnt <= '0;
        div_cur <= DIV;
      end

      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);

      if (pop) begin
        FD     <= mem[rd_ptr];
        SLWRN  <= 1'b0;
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end else begin
        SLWRN  <= 1'b1;
      end

      case ({push, pop})
        2'b10:   level <= level + (FIFO_AW + 1)'(1);
        2'b01:   level <= level - (FIFO_AW + 1)'(1);
        default: level <= level;
      endcase

      if (start) begin
        DROP_CNT <= '0;
      end else if (drop && (DROP_CNT != 16'hFFFF)) begin
        DROP_CNT <= DROP_CNT + 16'd1;
      end

      // Full packets are committed by the FX2 itself, so the count wraps.
      if (start) begin
        pkt_cnt <= '0;
      end else if (!SLWRN && (PKT_LEN != '0)) begin
        if (pkt_cnt == PKT_LEN - PKT_W'(1)) pkt_cnt <= '0;
        else                                pkt_cnt <= pkt_cnt + PKT_W'(1);
      end
    end
  end

  // Control FSM with registered PKTENDN.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= S_IDLE;
      PKTENDN <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          PKTENDN <= 1'b1;
          if (ENABLE) state <= S_STREAM;
        end
        S_STREAM: begin
          if (!ENABLE) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (drain_done) begin
            if ((PKT_LEN != '0) && (pkt_cnt != '0)) state <= S_PKTEND;
            else                                   state <= S_IDLE;
          end
        end
        S_PKTEND: begin
          // Stay here through the single low cycle of PKTENDN so BUSY
          // covers the commit.
          if (!PKTENDN) begin
            PKTENDN <= 1'b1;
            state   <= S_IDLE;
          end else if (FULLN) begin
            PKTENDN <= 1'b0;
          end
        end
        default: begin
          PKTENDN <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fx2_stream_writer.sv
module tb_fx2_stream_writer;

  localparam int DATA_W  = 8;
  localparam int FIFO_AW = 4;
  localparam int DIV_W   = 26;
  localparam int PKT_W   = 16;
  localparam int DEPTH   = 2 ** FIFO_AW;

  logic               CLK;
  logic               RESET;
  logic               ENABLE;
  logic [DIV_W-1:0]   DIV;
  logic [PKT_W-1:0]   PKT_LEN;
  logic [DATA_W-1:0]  SAMPLE;
  logic               FULLN;
  logic [DATA_W-1:0]  FD;
  logic               SLWRN;
  logic               PKTENDN;
  logic               BUSY;
  logic [FIFO_AW:0]   LEVEL;
  logic [15:0]        DROP_CNT;

  fx2_stream_writer #(
    .DATA_W(DATA_W), .FIFO_AW(FIFO_AW), .DIV_W(DIV_W), .PKT_W(PKT_W)
  ) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .DIV(DIV), .PKT_LEN(PKT_LEN),
    .SAMPLE(SAMPLE), .FULLN(FULLN), .FD(FD), .SLWRN(SLWRN), .PKTENDN(PKTENDN),
    .BUSY(BUSY), .LEVEL(LEVEL), .DROP_CNT(DROP_CNT)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0;
  int n_err = 0;

  // Model mode: 0 idle, 1 streaming, 2 draining, 3 committing short packet.
  int               m_mode;
  logic [DATA_W-1:0] exp_q[$];
  logic             m_slwrn;
  logic             m_pktendn;
  logic [DATA_W-1:0] m_fd;
  int               m_drop;
  int               m_words_in_pkt;
  int               m_phase;
  int               m_div;

  bit ramp;
  int words;
  int pe_pulses;
  bit prev_pe_low;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    exp_q.delete();
    m_slwrn = 1'b1;
    m_pktendn = 1'b1;
    m_fd = '0;
    m_drop = 0;
    m_words_in_pkt = 0;
    m_phase = 0;
    m_div = 0;
    prev_pe_low = 1'b0;
  endtask

  // One clock edge of behaviour, computed from the rules with a queue.
  task automatic model_edge();
    int  mode0   = m_mode;
    int  size0   = exp_q.size();
    bit  wrote0  = !m_slwrn;
    bit  pe0     = m_pktendn;
    int  pkt0    = m_words_in_pkt;
    int  period  = (m_div == 0) ? 1 : m_div;
    bit  take    = (mode0 == 1 || mode0 == 2) && size0 > 0 && FULLN === 1'b1;
    bit  sampled = (mode0 == 1) && (m_phase == 0);

    if (wrote0 && PKT_LEN != 0) m_words_in_pkt = (m_words_in_pkt + 1) % int'(PKT_LEN);

    if (take) begin
      m_fd = exp_q.pop_front();
      m_slwrn = 1'b0;
    end else begin
      m_slwrn = 1'b1;
    end

    if (sampled) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(SAMPLE);
      else if (m_drop < 65535) m_drop++;
    end

    if (mode0 == 1) begin
      if (m_phase + 1 >= period) begin
        m_phase = 0;
        m_div = int'(DIV);
      end else begin
        m_phase++;
      end
    end else begin
      m_phase = 0;
      m_div = int'(DIV);
    end

    case (mode0)
      0: if (ENABLE) begin m_mode = 1; m_drop = 0; m_words_in_pkt = 0; end
      1: if (!ENABLE) m_mode = 2;
      2: if (size0 == 0 && !wrote0) m_mode = (PKT_LEN != 0 && pkt0 != 0) ? 3 : 0;
      3: begin
        if (!pe0) begin m_pktendn = 1'b1; m_mode = 0; end
        else if (FULLN) m_pktendn = 1'b0;
      end
      default: m_mode = 0;
    endcase
  endtask

  task automatic compare_outputs();
    if (prev_pe_low) check("busy_after_pktend", BUSY, 1'b0);
    check("slwrn", SLWRN, m_slwrn);
    check("fd", FD, m_fd);
    check("pktendn", PKTENDN, m_pktendn);
    check("busy", BUSY, (m_mode != 0));
    check("level", LEVEL, exp_q.size());
    check("drop_cnt", DROP_CNT, m_drop);
    if (SLWRN === 1'b0) words++;
    if (PKTENDN === 1'b0) pe_pulses++;
    prev_pe_low = (PKTENDN === 1'b0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    if (RESET) model_reset();
    else model_edge();
    @(negedge CLK);
    compare_outputs();
    if (ramp) SAMPLE = SAMPLE + 1'b1;
    else SAMPLE = DATA_W'($urandom);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic drain(input bit rnd);
    int budget = 400;
    ENABLE = 1'b0;
    while (budget > 0 && !(m_mode == 0 && BUSY === 1'b0)) begin
      if (rnd) begin
        FULLN = ($urandom_range(0, 3) != 0);
        // ENABLE re-asserted mid-drain must not restart the stream.
        ENABLE = (m_mode >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        FULLN = 1'b1;
      end
      step();
      budget--;
    end
    check("drain_idle", BUSY, 1'b0);
    ENABLE = 1'b0;
    FULLN = 1'b1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_fd"}, FD, 0);
    check({pfx, "_slwrn"}, SLWRN, 1);
    check({pfx, "_pktendn"}, PKTENDN, 1);
    check({pfx, "_busy"}, BUSY, 0);
    check({pfx, "_level"}, LEVEL, 0);
    check({pfx, "_drop"}, DROP_CNT, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RESET = 1'b1;
    ENABLE = 1'b0;
    DIV = 1;
    PKT_LEN = 0;
    SAMPLE = '0;
    FULLN = 1'b1;
    ramp = 1'b1;
    words = 0;
    pe_pulses = 0;
    model_reset();

    run(2);
    check_reset_outputs("rst");
    RESET = 1'b0;
    run(2);

    // Decimate by 4, ramp data, FX2 always has room.
    DIV = 4; PKT_LEN = 512; FULLN = 1'b1; SAMPLE = '0; ENABLE = 1'b1;
    run(60);
    check("t1_drop", DROP_CNT, 0);
    drain(1'b0);

    // Full stall: 40 samples at full rate into a 16-word FIFO.
    DIV = 1; PKT_LEN = 512; FULLN = 1'b0; ENABLE = 1'b1;
    run(41);
    check("t2_level", LEVEL, 16);
    check("t2_drop", DROP_CNT, 24);
    FULLN = 1'b1;
    run(10);
    check("t2_level_hold", LEVEL, 16);
    check("t2_drop_hold", DROP_CNT, 24);
    drain(1'b0);

    // 19 words with 8-word packets: one short-packet commit.
    DIV = 2; PKT_LEN = 8; FULLN = 1'b1; words = 0; pe_pulses = 0; ENABLE = 1'b1;
    run(38);
    drain(1'b0);
    check("t3_words", words, 19);
    check("t3_pktend", pe_pulses, 1);

    // Exactly 16 words: packets auto-committed, no PKTEND.
    DIV = 2; PKT_LEN = 8; FULLN = 1'b1; words = 0; pe_pulses = 0; ENABLE = 1'b1;
    run(32);
    drain(1'b0);
    check("t4_words", words, 16);
    check("t4_pktend", pe_pulses, 0);

    // Asynchronous reset with 5 words buffered.
    DIV = 1; PKT_LEN = 8; FULLN = 1'b0; ENABLE = 1'b1;
    run(6);
    check("t5_level", LEVEL, 5);
    #2 RESET = 1'b1;
    #1 check_reset_outputs("arst");
    model_reset();
    step();
    RESET = 1'b0;
    FULLN = 1'b1;
    ramp = 1'b0;
    run(20);
    check("t5_drop", DROP_CNT, 0);
    drain(1'b0);

    // Randomized rounds: divisor, packet size, FX2 back-pressure, ENABLE.
    for (int r = 0; r < 12; r++) begin
      DIV = $urandom_range(0, 5);
      PKT_LEN = $urandom_range(0, 7);
      ENABLE = 1'b1;
      repeat ($urandom_range(20, 80)) begin
        FULLN = ($urandom_range(0, 3) != 0);
        step();
      end
      drain(1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
